pll_lock_supervisor: RTL

//  Parametrised reset/lock sequencer for up to 4 PLL instances. Each channel runs its own FSM:
//  - drives the PLL reset and the charge-pump (ICPSEL) and loop-filter (LPFRES) settings;
//  - qualifies lock, retries on timeout or lock loss, and flags permanent failure.

---
 rtl/pll_lock_supervisor_if.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its PLL-side/system-side neighbours.
`timescale 1ns/1ps
interface pll_lock_supervisor_if #(
  parameter int NUM_PLL = 1
);
  logic [NUM_PLL-1:0]   pll_lock;
  logic [NUM_PLL-1:0]   recal;
  logic [NUM_PLL-1:0]   pll_rst;
  logic [6*NUM_PLL-1:0] icpsel;
  logic [3*NUM_PLL-1:0] lpfres;
  logic [NUM_PLL-1:0]   locked;
  logic [NUM_PLL-1:0]   fail;
  logic                 all_locked;

  modport master (
    output pll_lock, recal,
    input  pll_rst, icpsel, lpfres, locked, fail, all_locked
  );

  modport slave (
    input  pll_lock, recal,
    output pll_rst, icpsel, lpfres, locked, fail, all_locked
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Per-channel PLL reset/lock sequencer: reset hold, lock timeout with retry, stability qualification.
// Lock input sees 2 sync cycles; locked is registered, all_locked one cycle later; no backpressure.
`timescale 1ns/1ps
module pll_lock_supervisor #(
  parameter int          NUM_PLL       = 1,
  parameter int          CLK_PERIOD_NS = 20,
  parameter logic [31:0] MULTI_FAC     = {4{8'd26}},
  parameter int          RST_HOLD_NS   = 1000,
  parameter int          LOCK_TO_NS    = 200000,
  parameter int          STABLE_CYC    = 1024,
  parameter int          MAX_RETRY     = 3
) (
  input logic                   init_clk,
  input logic                   resetn,
  pll_lock_supervisor_if.slave  bus
);

  localparam int RST_CYC = RST_HOLD_NS / CLK_PERIOD_NS;
  localparam int TO_CYC  = LOCK_TO_NS / CLK_PERIOD_NS;
  localparam int MAX_A   = (RST_CYC > TO_CYC) ? RST_CYC : TO_CYC;
  localparam int MAX_CYC = (MAX_A > STABLE_CYC) ? MAX_A : STABLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST   = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT,
    ST_STABLE,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  if (NUM_PLL < 1 || NUM_PLL > 4) begin : g_err_num
    $error("NUM_PLL must be 1..4");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_err_retry
    $error("MAX_RETRY must be 1..15");
  end
  if (RST_CYC < 1 || TO_CYC < 1 || STABLE_CYC < 2) begin : g_err_cyc
    $error("hold/timeout/stable cycle counts out of range");
  end

  function automatic logic [5:0] icp_of(input logic [7:0] m);
    if (m <= 8'd16)      return 6'd6;
    else if (m <= 8'd32) return 6'd12;
    else if (m <= 8'd64) return 6'd24;
    else                 return 6'd48;
  endfunction

  function automatic logic [2:0] lpf_of(input logic [7:0] m);
    if (m <= 8'd16)      return 3'd2;
    else if (m <= 8'd32) return 3'd3;
    else if (m <= 8'd64) return 3'd4;
    else                 return 3'd5;
  endfunction

  logic [NUM_PLL-1:0] sync1_q;
  logic [NUM_PLL-1:0] sync2_q;
  logic [NUM_PLL-1:0] locked_vec;
  logic               all_locked_q;

  always_ff @(posedge init_clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      all_locked_q <= 1'b0;
    end else begin
      sync1_q      <= bus.pll_lock;
      sync2_q      <= sync1_q;
      all_locked_q <= &locked_vec;
    end
  end

  assign bus.all_locked = all_locked_q;

  for (genvar i = 0; i < NUM_PLL; i++) begin : g_ch
    localparam logic [7:0] MF = MULTI_FAC[8*i +: 8];

    if (MF == 8'd0) begin : g_err_mf
      $error("MULTI_FAC channel value of zero");
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       retry_q;
    logic             rst_q;
    logic             lock_q;
    logic             fail_q;
    logic             lk;

    assign lk = sync2_q[i];

    // cnt_q is the hold timer in RESET, the timeout in WAIT, and the
    // consecutive-lock count in STABLE (the WAIT->STABLE sample counts as the first).
    always_ff @(posedge init_clk or negedge resetn) begin
      if (!resetn) begin
        state_q <= ST_RESET;
        cnt_q   <= '0;
        retry_q <= '0;
        rst_q   <= 1'b1;
        lock_q  <= 1'b0;
        fail_q  <= 1'b0;
      end else if (bus.recal[i]) begin
        state_q <= ST_RESET;
        cnt_q   <= '0;
        retry_q <= '0;
        rst_q   <= 1'b1;
        lock_q  <= 1'b0;
        fail_q  <= 1'b0;
      end else begin
        lock_q <= (state_q == ST_LOCKED) && lk;
        case (state_q)
          ST_RESET: begin
            if (cnt_q == RST_LAST) begin
              state_q <= ST_WAIT;
              cnt_q   <= '0;
              rst_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_WAIT: begin
            if (lk) begin
              state_q <= ST_STABLE;
              cnt_q   <= CNT_ONE;
            end else if (cnt_q == TO_LAST) begin
              cnt_q   <= '0;
              rst_q   <= 1'b1;
              retry_q <= retry_q + 4'd1;
              if (retry_q == RETRY_LAST) begin
                state_q <= ST_FAIL;
                fail_q  <= 1'b1;
              end else begin
                state_q <= ST_RESET;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_STABLE: begin
            if (!lk) begin
              state_q <= ST_WAIT;
              cnt_q   <= '0;
            end else if (cnt_q == STB_LAST) begin
              state_q <= ST_LOCKED;
              cnt_q   <= '0;
              retry_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_LOCKED: begin
            if (!lk) begin
              state_q <= ST_RESET;
              cnt_q   <= '0;
              rst_q   <= 1'b1;
            end
          end
          ST_FAIL: begin
            rst_q  <= 1'b1;
            fail_q <= 1'b1;
          end
          default: begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
          end
        endcase
      end
    end

    assign bus.pll_rst[i]      = rst_q;
    assign bus.locked[i]       = lock_q;
    assign bus.fail[i]         = fail_q;
    assign locked_vec[i]       = lock_q;
    assign bus.icpsel[6*i +: 6] = icp_of(MF);
    assign bus.lpfres[3*i +: 3] = lpf_of(MF);
  end

endmodule
